spike_packetizer: RTL and testbench

//  Transmit side of the neuron<->router spike link, in the neuron_clk domain.
//  - Captures the fired-neuron vector once per time step.
//  - Encodes each set bit into one 32-bit spike packet addressed to a fixed destination core.
//  - Serialises each packet into flits for the router's spike input buffer.
//  - The destination interface rebuilds packets LSB-flit-first and decodes axon_id.

---
 rtl/spike_packetizer_if.sv | 25 ++
 rtl/spike_packetizer.sv | 126 ++++++++++++
 tb/tb_spike_packetizer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spike_packetizer_if.sv
// Spike link bundle: neuron-side control/status plus the flit port toward the router.
interface spike_packetizer_if #(
    parameter int NUM_NEURONS = 2,
    parameter int flit_size   = 4
);
    logic                   start;
    logic                   spike_valid;
    logic [NUM_NEURONS-1:0] spike_in;
    logic                   router_full;
    logic                   write_en;
    logic [flit_size-1:0]   data_out;
    logic                   busy;
    logic                   done;
    logic                   overflow;

    modport master (
        input  start, spike_valid, spike_in, router_full,
        output write_en, data_out, busy, done, overflow
    );

    modport slave (
        output start, spike_valid, spike_in, router_full,
        input  write_en, data_out, busy, done, overflow
    );
endinterface

// File: rtl/spike_packetizer.sv
// Turns one fired-neuron vector per time step into address-coded spike packets
// and streams them LSB-flit-first into the router's spike input buffer.
module spike_packetizer #(
    parameter int packet_size          = 32,
    parameter int flit_size            = 4,
    parameter int x_address_length     = 8,
    parameter int y_address_length     = 8,
    parameter int NUM_NEURONS          = 2,
    parameter int NEURON_CNT_BIT_WIDTH = 1,
    parameter int DST_X                = 1,
    parameter int DST_Y                = 1
) (
    input  logic neuron_clk,
    input  logic rst_n,
    spike_packetizer_if.master lnk
);
    localparam int FLITS = packet_size / flit_size;
    localparam int CNT_W = (FLITS > 1) ? $clog2(FLITS) : 1;
    localparam int IDX_LSB = x_address_length + y_address_length;

    typedef enum logic [1:0] {IDLE, SCAN, SEND} state_t;

    state_t                     state, state_nxt;
    logic [NUM_NEURONS-1:0]     pending;
    logic [packet_size-1:0]     shift;
    logic [CNT_W-1:0]           flit_cnt;
    logic                       we_q, done_q, ovf_q;
    logic [flit_size-1:0]       dout_q;

    logic [NEURON_CNT_BIT_WIDTH-1:0] sel_idx;
    logic                       sel_vld;
    logic [packet_size-1:0]     pkt;
    logic                       busy_i, accept, ovf_evt;
    logic                       load_pkt, scan_empty, send_fire, last_flit;

    // Lowest set bit wins: scan downward so the final assignment is the lowest index.
    always_comb begin
        sel_idx = '0;
        sel_vld = 1'b0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_idx = NEURON_CNT_BIT_WIDTH'(i);
                sel_vld = 1'b1;
            end
        end
    end

    always_comb begin
        pkt = '0;
        pkt[x_address_length-1:0]                   = x_address_length'(DST_X);
        pkt[x_address_length +: y_address_length]   = y_address_length'(DST_Y);
        pkt[IDX_LSB +: NEURON_CNT_BIT_WIDTH]        = sel_idx;
    end

    // The done cycle counts as busy so a vector landing on it is flagged rather than half-accepted.
    assign busy_i    = (state != IDLE) || done_q;
    assign accept    = lnk.spike_valid && !busy_i;
    assign ovf_evt   = lnk.spike_valid && busy_i;
    assign last_flit = (flit_cnt == CNT_W'(FLITS - 1));

    always_ff @(posedge neuron_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SCAN;
            SCAN:    state_nxt = sel_vld ? SEND : IDLE;
            SEND:    if (!lnk.router_full && last_flit) state_nxt = SCAN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_pkt   = 1'b0;
        scan_empty = 1'b0;
        send_fire  = 1'b0;
        case (state)
            SCAN: begin
                load_pkt   = sel_vld;
                scan_empty = !sel_vld;
            end
            SEND:    send_fire = !lnk.router_full;
            default: ;
        endcase
    end

    always_ff @(posedge neuron_clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            shift    <= '0;
            flit_cnt <= '0;
            we_q     <= 1'b0;
            dout_q   <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (accept)
                pending <= lnk.spike_in;
            else if (load_pkt)
                pending <= pending & ~(NUM_NEURONS'(1) << sel_idx);

            if (load_pkt) begin
                shift    <= pkt;
                flit_cnt <= '0;
            end else if (send_fire) begin
                shift    <= shift >> flit_size;
                flit_cnt <= flit_cnt + 1'b1;
            end

            we_q <= send_fire;
            if (send_fire) dout_q <= shift[flit_size-1:0];
            done_q <= scan_empty;
            // start clears the old flag; a same-cycle overflow event still registers.
            ovf_q  <= (ovf_q && !lnk.start) || ovf_evt;
        end
    end

    assign lnk.write_en = we_q;
    assign lnk.data_out = dout_q;
    assign lnk.busy     = busy_i;
    assign lnk.done     = done_q;
    assign lnk.overflow = ovf_q;
endmodule

// File: tb/tb_spike_packetizer.sv
// Directed bench for spike_packetizer: flit scoreboard built from packet arithmetic plus literal timing checks.
module tb_spike_packetizer;
    localparam int NN = 4;

    logic neuron_clk = 1'b0;
    logic rst_n      = 1'b0;
    int   cyc        = 0;
    int   n_chk      = 0;
    int   n_err      = 0;

    spike_packetizer_if #(.NUM_NEURONS(NN), .flit_size(4)) lnk ();

    spike_packetizer #(
        .packet_size(32), .flit_size(4), .x_address_length(8), .y_address_length(8),
        .NUM_NEURONS(NN), .NEURON_CNT_BIT_WIDTH(2), .DST_X(3), .DST_Y(5)
    ) dut (
        .neuron_clk(neuron_clk),
        .rst_n     (rst_n),
        .lnk       (lnk)
    );

    always #5 neuron_clk = ~neuron_clk;
    always @(posedge neuron_clk) cyc <= cyc + 1;

    int   exp_q[$];
    int   wr_cyc[$];
    int   wr_dat[$];
    int   done_cyc[$];
    logic busy_log[4096];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected flit stream for a vector: one packet per set bit, lowest index first.
    task automatic push_vec(input logic [NN-1:0] v);
        for (int idx = 0; idx < NN; idx++) begin
            if (v[idx]) begin
                int p;
                p = 3 + (5 << 8) + (idx << 16);
                for (int k = 0; k < 8; k++) exp_q.push_back((p >> (4 * k)) & 15);
            end
        end
    endtask

    always @(negedge neuron_clk) begin
        busy_log[cyc % 4096] = lnk.busy;
        if (rst_n) begin
            if (lnk.write_en) begin
                wr_cyc.push_back(cyc);
                wr_dat.push_back(int'(lnk.data_out));
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_flit: got %0d expected no write (cycle %0d)", lnk.data_out, cyc);
                end else begin
                    chk("flit_data", int'(lnk.data_out), exp_q.pop_front());
                end
            end
            if (lnk.done) begin
                done_cyc.push_back(cyc);
                chk("flits_left_at_done", exp_q.size(), 0);
            end
        end
    end

    task automatic clear_logs();
        wr_cyc.delete();
        wr_dat.delete();
        done_cyc.delete();
    endtask

    task automatic pulse(input logic [NN-1:0] v, input bit acc, input bit st, output int t);
        @(posedge neuron_clk); #1;
        lnk.spike_valid = 1'b1;
        lnk.spike_in    = v;
        lnk.start       = st;
        t = cyc;
        if (acc) push_vec(v);
        @(posedge neuron_clk); #1;
        lnk.spike_valid = 1'b0;
        lnk.start       = 1'b0;
    endtask

    task automatic start_pulse();
        @(posedge neuron_clk); #1;
        lnk.start = 1'b1;
        @(posedge neuron_clk); #1;
        lnk.start = 1'b0;
    endtask

    task automatic wait_quiet(input string name);
        int i;
        for (i = 0; i < 400; i++) begin
            @(negedge neuron_clk); #1;
            if (!lnk.busy) break;
        end
        if (i == 400) begin
            n_chk++;
            n_err++;
            $display("FAIL %s_timeout: got busy expected idle", name);
        end
        @(negedge neuron_clk); #1;
    endtask

    task automatic wait_writes(input string name, input int n);
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge neuron_clk); #1;
            if (wr_cyc.size() >= n) break;
        end
        if (i == 100) begin
            n_chk++;
            n_err++;
            $display("FAIL %s_timeout: got %0d writes expected %0d", name, wr_cyc.size(), n);
        end
    endtask

    initial begin
        int t;
        int lit1[8];
        lnk.start       = 1'b0;
        lnk.spike_valid = 1'b0;
        lnk.spike_in    = '0;
        lnk.router_full = 1'b0;
        lit1 = '{3, 0, 5, 0, 2, 0, 0, 0};

        #12;
        chk("rst_write_en", int'(lnk.write_en), 0);
        chk("rst_data_out", int'(lnk.data_out), 0);
        chk("rst_busy",     int'(lnk.busy),     0);
        chk("rst_done",     int'(lnk.done),     0);
        chk("rst_overflow", int'(lnk.overflow), 0);
        @(negedge neuron_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge neuron_clk);

        // single packet, neuron 2
        clear_logs();
        pulse(4'b0100, 1'b1, 1'b0, t);
        wait_quiet("t1");
        chk("t1_busy_t1", int'(busy_log[(t + 1) % 4096]), 1);
        chk("t1_nwrites", wr_cyc.size(), 8);
        if (wr_cyc.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                chk("t1_flit_cycle", wr_cyc[k], t + 3 + k);
                chk("t1_flit_lit",   wr_dat[k], lit1[k]);
            end
        end
        chk("t1_ndone", done_cyc.size(), 1);
        if (done_cyc.size() == 1) chk("t1_done_cycle", done_cyc[0], t + 11);

        // three packets, axon ids 0,1,3
        clear_logs();
        pulse(4'b1011, 1'b1, 1'b0, t);
        wait_quiet("t2");
        chk("t2_nwrites", wr_cyc.size(), 24);
        if (wr_cyc.size() == 24) begin
            chk("t2_first",   wr_cyc[0],  t + 3);
            chk("t2_gap1",    wr_cyc[8]  - wr_cyc[7],  2);
            chk("t2_gap2",    wr_cyc[16] - wr_cyc[15], 2);
            chk("t2_last",    wr_cyc[23], t + 28);
            chk("t2_axon_a",  wr_dat[4],  0);
            chk("t2_axon_b",  wr_dat[12], 1);
            chk("t2_axon_c",  wr_dat[20], 3);
        end
        chk("t2_ndone", done_cyc.size(), 1);
        if (done_cyc.size() == 1) chk("t2_done_cycle", done_cyc[0], t + 29);

        // empty vector
        clear_logs();
        pulse(4'b0000, 1'b1, 1'b0, t);
        wait_quiet("t3");
        chk("t3_nwrites", wr_cyc.size(), 0);
        chk("t3_ndone",   done_cyc.size(), 1);
        if (done_cyc.size() == 1) chk("t3_done_cycle", done_cyc[0], t + 2);
        chk("t3_busy_t1", int'(busy_log[(t + 1) % 4096]), 1);
        chk("t3_busy_t2", int'(busy_log[(t + 2) % 4096]), 1);
        chk("t3_busy_t3", int'(busy_log[(t + 3) % 4096]), 0);

        // back-pressure after flit 2
        clear_logs();
        pulse(4'b0001, 1'b1, 1'b0, t);
        wait_writes("t4", 3);
        lnk.router_full = 1'b1;
        repeat (5) @(negedge neuron_clk);
        #1 lnk.router_full = 1'b0;
        wait_quiet("t4");
        chk("t4_nwrites", wr_cyc.size(), 8);
        if (wr_cyc.size() == 8) begin
            chk("t4_flit2_cycle", wr_cyc[2], t + 5);
            chk("t4_flit3_cycle", wr_cyc[3], t + 11);
            chk("t4_flit3_data",  wr_dat[3], 0);
            chk("t4_flit4_data",  wr_dat[4], 0);
            chk("t4_flit2_data",  wr_dat[2], 5);
        end

        // overflow while busy, then start clears it
        clear_logs();
        pulse(4'b0011, 1'b1, 1'b0, t);
        repeat (4) @(negedge neuron_clk);
        pulse(4'b1100, 1'b0, 1'b0, t);
        chk("t5_overflow_set", int'(lnk.overflow), 1);
        wait_quiet("t5");
        chk("t5_nwrites", wr_cyc.size(), 16);
        chk("t5_ndone",   done_cyc.size(), 1);
        chk("t5_overflow_sticky", int'(lnk.overflow), 1);
        start_pulse();
        chk("t5_overflow_clr", int'(lnk.overflow), 0);
        pulse(4'b1000, 1'b0, 1'b0, t);
        #0;
        push_vec(4'b1000);
        repeat (2) @(negedge neuron_clk);
        pulse(4'b0001, 1'b0, 1'b0, t);
        chk("t5_overflow_again", int'(lnk.overflow), 1);
        wait_quiet("t5b");
        clear_logs();
        pulse(4'b0010, 1'b1, 1'b1, t);
        chk("t5_start_and_spike_ovf", int'(lnk.overflow), 0);
        wait_quiet("t5c");
        chk("t5_start_and_spike_nwrites", wr_cyc.size(), 8);

        // reset during flit 4
        clear_logs();
        pulse(4'b0100, 1'b1, 1'b0, t);
        wait_writes("t6", 5);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("t6_rst_write_en", int'(lnk.write_en), 0);
        chk("t6_rst_data_out", int'(lnk.data_out), 0);
        chk("t6_rst_busy",     int'(lnk.busy),     0);
        chk("t6_rst_done",     int'(lnk.done),     0);
        chk("t6_rst_overflow", int'(lnk.overflow), 0);
        repeat (2) @(negedge neuron_clk);
        rst_n = 1'b1;
        repeat (3) @(negedge neuron_clk);
        chk("t6_no_partial", int'(lnk.write_en), 0);
        clear_logs();
        pulse(4'b1000, 1'b1, 1'b0, t);
        wait_quiet("t6");
        chk("t6_nwrites", wr_cyc.size(), 8);
        if (wr_cyc.size() == 8) begin
            chk("t6_first_cycle", wr_cyc[0], t + 3);
            chk("t6_flit0", wr_dat[0], 3);
            chk("t6_flit4", wr_dat[4], 3);
        end
        chk("t6_scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
